// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//
// Turns raw, bouncing, active-low push buttons into clean per-key events
// synchronous to CLOCK_50. Each channel is independent and has its own
// 2-flop synchronizer, debounce counter, hold/repeat counter and state
// machine.
//
// Ports:
//   CLOCK_50     sole clock, everything updates on posedge
//   reset        synchronous, active-high
//   KEY          raw asynchronous buttons, active-low (0 = pressed)
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press and on every auto-repeat
//   key_repeat   1-cycle pulse on auto-repeat only (coincides with key_press)
//   key_release  1-cycle pulse on accepted release
//
// Event outputs are plain registered pulses with no handshake: a consumer
// must sample them on every CLOCK_50 edge; there is no ready/back-pressure.
// The per-key state register g_key[k].state is the observable FSM state.

module key_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_release
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST   = HW'(REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HCNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEATING    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } key_state_t;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          sync1, sync2;
    logic          p;
    key_state_t    state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic          lvl_q, lvl_n;
    logic          press_q, press_n;
    logic          rep_q, rep_n;
    logic          rel_q, rel_n;

    // Synchronizer presets to "released" so a key held through reset is
    // seen as a fresh press afterwards, with full debounce latency.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= KEY[k];
        sync2 <= sync1;
      end
    end

    assign p = ~sync2;

    // Next-state and next-output logic. Counters are cleared on every
    // state change so each state starts its own timing from zero.
    always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      lvl_n   = lvl_q;
      press_n = 1'b0;
      rep_n   = 1'b0;
      rel_n   = 1'b0;

      unique case (state)
        ST_RELEASED: begin
          if (p) begin
            state_n = ST_PRESS_WAIT;
            dcnt_n  = '0;
            hcnt_n  = '0;
          end
        end

        ST_PRESS_WAIT: begin
          if (!p) begin
            state_n = ST_RELEASED;
            dcnt_n  = '0;
            hcnt_n  = '0;
          end else if (dcnt == DCNT_LAST) begin
            state_n = ST_HELD;
            dcnt_n  = '0;
            hcnt_n  = '0;
            lvl_n   = 1'b1;
            press_n = 1'b1;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end

        ST_HELD: begin
          if (!p) begin
            state_n = ST_RELEASE_WAIT;
            dcnt_n  = '0;
            hcnt_n  = '0;
          end else if ((REPEAT_EN != 0) && (hcnt == DELAY_LAST)) begin
            state_n = ST_REPEATING;
            dcnt_n  = '0;
            hcnt_n  = '0;
            press_n = 1'b1;
            rep_n   = 1'b1;
          end else if (hcnt != HCNT_MAX) begin
            // Saturating so a long hold with repeat disabled never wraps.
            hcnt_n = hcnt + HW'(1);
          end
        end

        ST_REPEATING: begin
          if (!p) begin
            state_n = ST_RELEASE_WAIT;
            dcnt_n  = '0;
            hcnt_n  = '0;
          end else if (hcnt == PER_LAST) begin
            hcnt_n  = '0;
            press_n = 1'b1;
            rep_n   = 1'b1;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end

        ST_RELEASE_WAIT: begin
          if (p) begin
            // Release bounce: back to HELD, repeat timing restarts from
            // the initial delay, level stays high and nothing pulses.
            state_n = ST_HELD;
            dcnt_n  = '0;
            hcnt_n  = '0;
          end else if (dcnt == DCNT_LAST) begin
            state_n = ST_RELEASED;
            dcnt_n  = '0;
            hcnt_n  = '0;
            lvl_n   = 1'b0;
            rel_n   = 1'b1;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end

        default: begin
          state_n = ST_RELEASED;
          dcnt_n  = '0;
          hcnt_n  = '0;
          lvl_n   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state   <= ST_RELEASED;
        dcnt    <= '0;
        hcnt    <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rep_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_n;
        dcnt    <= dcnt_n;
        hcnt    <= hcnt_n;
        lvl_q   <= lvl_n;
        press_q <= press_n;
        rep_q   <= rep_n;
        rel_q   <= rel_n;
      end
    end

    assign key_level[k]   = lvl_q;
    assign key_press[k]   = press_q;
    assign key_repeat[k]  = rep_q;
    assign key_release[k] = rel_q;
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Testbench for key_input_conditioner.
// Two instances share clock and reset: dut_a with auto-repeat (channels 0-3
// of the scoreboard) and dut_b with auto-repeat disabled (channels 4-7).
// Expected events are derived from the documented latencies and pushed to a
// per-channel queue when a key waveform is driven; a negedge monitor pops
// and compares them as the DUT produces pulses.

module tb_key_input_conditioner;

  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int BIG = 1 << 20;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REP   = 3'b110;
  localparam logic [2:0] K_REL   = 3'b001;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] key_a = 4'hF;
  logic [3:0] key_b = 4'hF;
  logic [3:0] lvl_a, prs_a, rep_a, rel_a;
  logic [3:0] lvl_b, prs_b, rep_b, rel_b;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;
  logic rst_q  = 1'b1;
  bit   mon_en = 1'b0;

  logic [26:0] exp_q[8][$];
  logic        lvl_exp[8];

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    rst_q  <= reset;
  end

  key_input_conditioner #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .KEY(key_a),
    .key_level(lvl_a), .key_press(prs_a),
    .key_repeat(rep_a), .key_release(rel_a)
  );

  key_input_conditioner #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .KEY(key_b),
    .key_level(lvl_b), .key_press(prs_b),
    .key_repeat(rep_b), .key_release(rel_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_key(input int ch, input logic v);
    if (ch < 4) key_a[ch] = v;
    else        key_b[ch-4] = v;
  endtask

  task automatic push_ev(input int ch, input int c, input logic [2:0] kind);
    exp_q[ch].push_back({c[23:0], kind});
  endtask

  // Key low on edges t0..tl (first sample t0). Events at edges >= cut are
  // dropped (used when reset interrupts a hold).
  task automatic push_events(input int ch, input int t0, input int tl, input int cut);
    int pe;
    int r;
    if (tl - t0 + 1 < D + 1) return;
    pe = t0 + D + 2;
    if (pe < cut) push_ev(ch, pe, K_PRESS);
    if (ch < 4) begin
      r = pe + RD;
      while (r <= tl + 2 && r < cut) begin
        push_ev(ch, r, K_REP);
        r = r + RP;
      end
    end
    if (tl + D + 3 < cut) push_ev(ch, tl + D + 3, K_REL);
  endtask

  task automatic key_hold(input int ch, input int len);
    int t0;
    t0 = edge_n + 1;
    push_events(ch, t0, t0 + len - 1, BIG);
    set_key(ch, 1'b0);
    step(len);
    set_key(ch, 1'b1);
  endtask

  // scoreboard monitor
  logic [7:0]  m_lv, m_pr, m_rp, m_rl;
  logic [2:0]  m_obs, m_exp;
  logic [26:0] m_front;

  always @(negedge clk) begin
    if (mon_en) begin
      m_lv = {lvl_b, lvl_a};
      m_pr = {prs_b, prs_a};
      m_rp = {rep_b, rep_a};
      m_rl = {rel_b, rel_a};
      for (int ch = 0; ch < 8; ch++) begin
        m_obs = {m_pr[ch], m_rp[ch], m_rl[ch]};
        m_exp = 3'b000;
        if (rst_q) lvl_exp[ch] = 1'b0;
        if (exp_q[ch].size() > 0) begin
          m_front = exp_q[ch][0];
          if (m_front[26:3] == edge_n[23:0]) begin
            m_front = exp_q[ch].pop_front();
            m_exp   = m_front[2:0];
            if (m_exp == K_PRESS || m_exp == K_REP) lvl_exp[ch] = 1'b1;
            else if (m_exp == K_REL)                lvl_exp[ch] = 1'b0;
          end
        end
        if (m_obs != 3'b000 || m_exp != 3'b000)
          check($sformatf("event ch%0d", ch), {29'b0, m_obs}, {29'b0, m_exp});
        check($sformatf("level ch%0d", ch), {31'b0, m_lv[ch]}, {31'b0, lvl_exp[ch]});
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < 8; i++) lvl_exp[i] = 1'b0;

    // reset state
    reset = 1'b1;
    step(3);
    check("reset level",   {24'b0, lvl_b, lvl_a}, 32'd0);
    check("reset press",   {24'b0, prs_b, prs_a}, 32'd0);
    check("reset repeat",  {24'b0, rep_b, rep_a}, 32'd0);
    check("reset release", {24'b0, rel_b, rel_a}, 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    step(5);

    // clean press / release on key 0
    key_hold(0, 8);
    step(15);

    // glitch: 4 samples rejected, 5 samples accepted
    key_hold(1, 4);
    step(15);
    key_hold(1, 5);
    step(15);

    // auto-repeat on key 2
    key_hold(2, 40);
    step(15);

    // release bounce on key 2: 8 low, 3 high, 20 low
    t0 = edge_n + 1;
    push_ev(2, t0 + 6, K_PRESS);
    push_ev(2, t0 + 23, K_REP);
    push_ev(2, t0 + 26, K_REP);
    push_ev(2, t0 + 29, K_REP);
    push_ev(2, t0 + 32, K_REP);
    push_ev(2, t0 + 37, K_REL);
    set_key(2, 1'b0);
    step(8);
    set_key(2, 1'b1);
    step(3);
    set_key(2, 1'b0);
    step(20);
    set_key(2, 1'b1);
    step(15);

    // reset while key 3 is held and repeating, key kept low through reset
    t0 = edge_n + 1;
    push_events(3, t0, t0 + BIG, t0 + 19);
    set_key(3, 1'b0);
    step(19);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    key_hold(3, 15);
    step(15);

    // all four keys on the same edge, repeat enabled
    fork
      key_hold(0, 8);
      key_hold(1, 8);
      key_hold(2, 8);
      key_hold(3, 8);
    join
    step(15);

    // all four keys held long with repeat disabled
    fork
      key_hold(4, 30);
      key_hold(5, 30);
      key_hold(6, 30);
      key_hold(7, 30);
    join
    step(15);

    step(10);
    for (int ch = 0; ch < 8; ch++)
      check($sformatf("leftover ch%0d", ch), exp_q[ch].size(), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Input-side companion to the seven-segment display path. Conditions the raw, active-low, bouncing push-button inputs on KEY into clean per-key events (press, release, auto-repeat) and a debounced level, all synchronous to CLOCK_50.
- Downstream digit/counter logic consumes single-cycle event pulses and never sees raw KEY.

Parameters:
- N_KEYS, 4, number of independent key channels
- DEBOUNCE_CYCLES, 1_000_000, stable-sample count required to accept a level change (20 ms at 50 MHz); must be >= 1
- REPEAT_EN, 1, 1 enables auto-repeat while a key is held; 0 disables it
- REPEAT_DELAY, 25_000_000, cycles from the press pulse to the first repeat pulse (500 ms); must be >= 1
- REPEAT_PERIOD, 5_000_000, cycles between subsequent repeat pulses (100 ms); must be >= 1

Ports:
- CLOCK_50  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- KEY  in  N_KEYS  raw asynchronous buttons, active-low (0 = pressed)
- key_level  out  N_KEYS  debounced state, 1 = pressed
- key_press  out  N_KEYS  1-cycle pulse on accepted press and on every auto-repeat
- key_repeat  out  N_KEYS  1-cycle pulse on auto-repeat only; always coincides with key_press
- key_release  out  N_KEYS  1-cycle pulse on accepted release

Behaviour:
- One clock, CLOCK_50. Reset is synchronous and active-high. Channels are fully independent, with no shared counters and no priority between them.
- Reset (sampled at a posedge):
  - both synchronizer flops preset to 1 (released)
  - state = RELEASED, all counters = 0
  - all outputs = 0
  - no release pulse is emitted for a key that was held when reset asserted
  - a key held through reset is re-detected after reset deasserts, with full latency
- Synchronizer: 2-flop chain per key. Let p = ~sync2 (1 = pressed).
- Debounce counter dcnt:
  - width $clog2(DEBOUNCE_CYCLES)+1
  - cleared on every state entry
- Hold/repeat counter hcnt:
  - width sized for max(REPEAT_DELAY, REPEAT_PERIOD)
  - cleared on every state entry
- State machine per key:
  - RELEASED: if p, go to PRESS_WAIT.
  - PRESS_WAIT:
    - if !p, go to RELEASED (glitch rejected, no output)
    - else if dcnt == DEBOUNCE_CYCLES-1, go to HELD, set key_level = 1, pulse key_press
    - else dcnt++
  - HELD:
    - if !p, go to RELEASE_WAIT
    - else if REPEAT_EN and hcnt == REPEAT_DELAY-1, go to REPEATING and pulse key_press + key_repeat
    - else hcnt++ (hcnt saturates when REPEAT_EN = 0)
  - REPEATING:
    - if !p, go to RELEASE_WAIT
    - else if hcnt == REPEAT_PERIOD-1, pulse key_press + key_repeat and set hcnt = 0
    - else hcnt++
  - RELEASE_WAIT:
    - if p, go to HELD (bounce rejected; key_level stays 1, no pulses, repeat timing restarts from REPEAT_DELAY)
    - else if dcnt == DEBOUNCE_CYCLES-1, go to RELEASED, set key_level = 0, pulse key_release
    - else dcnt++
- Latency, with edge 0 = first posedge sampling KEY low:
  - key_press is high during the cycle after edge DEBOUNCE_CYCLES+2
  - a press is accepted only if KEY is sampled low on at least DEBOUNCE_CYCLES+1 consecutive edges; DEBOUNCE_CYCLES or fewer samples produce no output
  - release is symmetric
- Repeat timing:
  - first repeat pulse is exactly REPEAT_DELAY cycles after the press pulse
  - subsequent repeat pulses are every REPEAT_PERIOD cycles
- Pulse rules:
  - every pulse is exactly 1 cycle wide
  - key_press and key_release are never high together on the same key
  - key_level changes in the same cycle its press/release pulse is asserted
- All outputs are registered. There is no combinational path from KEY to any output.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1):
- Clean press: KEY[0] low from edge 0 -> key_press[0] high only after edge 6; key_level[0] = 1 from the same cycle; KEY[3:1] outputs stay 0.
- Glitch: KEY[1] low for exactly 4 edges, then high -> no pulses; key_level[1] stays 0. Low for 5 edges, then high -> press accepted, then release pulse 6 edges after the first high sample.
- Auto-repeat: hold KEY[2] low for 40 cycles -> press pulse at cycle P, repeat (press + repeat) pulses at P+10, P+13, P+16, ...; then release -> key_release 6 edges after the first high sample and no further repeats.
- Release bounce: while held, drive KEY high for 3 edges, then low -> no key_release, key_level stays 1, next repeat 10 cycles after re-entering HELD.
- Reset mid-hold: assert reset while KEY[3] is held and repeating -> all outputs 0 on the next cycle with no release pulse; deassert reset with KEY[3] still low -> press pulse 6 edges later.
- Simultaneous: all four keys pressed on the same edge -> four key_press bits asserted in the same cycle; REPEAT_EN=0 run -> holding yields no repeat pulses.
